cdc_reset_sequencer: RTL and testbench
======================================

# cdc_reset_sequencer

Parametrised reset controller. It collects several asynchronous reset requests, a PLL-lock indication and a software reset, and synchronises each asynchronous input through a configurable-depth flop chain. It stretches the combined request to a minimum hold time, then releases NUM_OUT active-low reset outputs one after another with a fixed step between them. It sits at the top of each clock domain and drives that domain's ordered sub-block resets, such as PLL-dependent logic first, then the datapath, then the peripherals.

## Interface
Parameters:
- NUM_SRC, 2: number of asynchronous active-low reset request inputs, >=1
- SYNC_STAGES, 2: synchroniser depth per asynchronous input, >=2
- NUM_OUT, 3: number of sequenced reset outputs, >=1
- HOLD_CYCLES, 16: cycles the combined request must stay inactive before the first release, >=1
- STEP_CYCLES, 8: cycles between consecutive output releases, >=1

Ports:
- Clocking and reset (decided for this block): one clock; reset is synchronous and active-high.
- clk_i  in  1  domain clock
- rst_i  in  1  synchronous reset, active high; overrides every other input
- src_rst_ni  in  NUM_SRC  asynchronous reset requests, active low
- pll_locked_i  in  1  asynchronous PLL lock; a low level is a request
- sw_rst_i  in  1  synchronous software reset request, active high, any length
- cause_clr_i  in  1  synchronous clear of cause_o
- rst_no  out  NUM_OUT  sequenced resets, active low; bit 0 is released first
- busy_o  out  1  high while any rst_no bit is low
- cause_o  out  NUM_SRC+2  sticky request causes:
  - bits [NUM_SRC-1:0]: sources
  - bit [NUM_SRC]: PLL unlock
  - bit [NUM_SRC+1]: software reset

## Operation
- Synchronisers:
  - Each src_rst_ni bit and pll_locked_i passes through a SYNC_STAGES flop chain. The chains have no asynchronous clear.
  - rst_i loads 0 into every stage, so all requests read as active after reset.
- Combined request: req = OR(~src_s) | ~locked_s | sw_rst_i, where src_s and locked_s are the last stages of the chains.
- FSM states:
  - ASSERT: all rst_no = 0 and busy_o = 1.
    - Counter cnt clears whenever req = 1 and increments on each edge where req = 0.
    - When cnt reaches HOLD_CYCLES, at that same edge: go to RELEASE, set rst_no[0] = 1, clear cnt.
  - RELEASE: cnt increments every edge; index k is the next output to release.
    - When cnt reaches STEP_CYCLES, release rst_no[k] and clear cnt.
    - Releasing rst_no[NUM_OUT-1] enters RUN at the same edge.
    - NUM_OUT = 1 goes from ASSERT directly to RUN.
  - RUN: all rst_no = 1 and busy_o = 0.
- Any req = 1 in RELEASE or RUN: go to ASSERT at the next edge, drive all rst_no = 0 at that edge, clear cnt and k.
- rst_i = 1 at any state: the next edge gives state ASSERT, cnt = 0, k = 0, all rst_no = 0, busy_o = 1, cause_o = 0, and all synchroniser stages = 0.
- cause_o:
  - A bit sets on each edge its synchronised request is active (sw bit: sw_rst_i = 1).
  - cause_clr_i clears all bits.
  - When set and clear occur together, set wins for that bit.
  - Bits are also set by the post-reset active synchroniser state. Software clears them after boot.
- Counter width: $clog2(max(HOLD_CYCLES, STEP_CYCLES)+1).
- Elaboration error on any parameter below its stated minimum.

## Timing
- Assertion latency:
  - Async input goes active before edge E: rst_no = 0 after edge E+SYNC_STAGES, i.e. SYNC_STAGES+1 edges including capture.
  - sw_rst_i = 1 sampled at edge E: rst_no = 0 after edge E.
- Release latency: all inputs inactive from edge E0 onward, with no sw_rst_i.
  - rst_no[0] rises at edge E0+SYNC_STAGES-1+HOLD_CYCLES.
  - rst_no[k] rises at edge E0+SYNC_STAGES-1+HOLD_CYCLES+k*STEP_CYCLES.
- busy_o falls at the same edge as rst_no[NUM_OUT-1] rises.
- After rst_i is released (last high at edge R) with inactive inputs:
  - rst_no[0] rises at edge R+SYNC_STAGES+HOLD_CYCLES.
  - Defaults: edge R+18, rst_no[1] at R+26, rst_no[2] at R+34.
- A request pulse shorter than one cycle may be missed; the minimum guaranteed pulse width is 2 clk_i periods.
- A glitch during HOLD restarts the hold count from zero; there is no partial credit.

## Test plan
- Power-up, defaults, all inputs inactive, rst_i high for 3 cycles (last high at edge R):
  - rst_no[0..2] rise at edges R+18, R+26 and R+34.
  - busy_o falls at edge R+34.
  - cause_o = 4'b0111 (all synchroniser bits set; sw bit clear).
- In RUN, pulse src_rst_ni[1] low for 3 cycles from edge E:
  - rst_no = 3'b000 after edge E+2.
  - cause_o[1] = 1.
  - Release sequence restarts, with rst_no[0] high 16 edges after req_s returns to 0.
- During RELEASE with rst_no = 3'b001, assert sw_rst_i for 1 cycle:
  - All outputs are low at the next edge.
  - cause_o[3] = 1.
  - Full HOLD and STEP timing is re-run.
- During HOLD at cnt = 10, drop pll_locked_i for 2 cycles:
  - cnt restarts.
  - rst_no[0] rises 16 edges after locked_s returns high.
  - cause_o[2] = 1.
- cause_clr_i and a new src_rst_ni[0] request in the same cycle:
  - cause_o[0] stays 1; other bits clear.
- Parameter sweep: NUM_OUT=1, SYNC_STAGES=3, HOLD_CYCLES=1, STEP_CYCLES=1.
  - The single output rises at edge R+4.
  - busy_o falls at the same edge.

Source files
------------

// File: rtl/cdc_reset_sequencer.sv
// Reset sequencer: synchronises async reset requests and PLL lock, stretches the
// combined request for a minimum hold time, then releases rst_no bits in order.
module cdc_reset_sequencer #(
   parameter int NUM_SRC     = 2,
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUT     = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_SRC-1:0] src_rst_ni,
   input  logic               pll_locked_i,
   input  logic               sw_rst_i,
   input  logic               cause_clr_i,
   output logic [NUM_OUT-1:0] rst_no,
   output logic               busy_o,
   output logic [NUM_SRC+1:0] cause_o
);

   localparam int NA      = NUM_SRC + 1;
   localparam int CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int KW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(NUM_OUT - 1);

   generate
      if (NUM_SRC < 1) begin : g_chk_num_src
         $error("NUM_SRC must be >= 1");
      end
      if (SYNC_STAGES < 2) begin : g_chk_sync
         $error("SYNC_STAGES must be >= 2");
      end
      if (NUM_OUT < 1) begin : g_chk_num_out
         $error("NUM_OUT must be >= 1");
      end
      if (HOLD_CYCLES < 1) begin : g_chk_hold
         $error("HOLD_CYCLES must be >= 1");
      end
      if (STEP_CYCLES < 1) begin : g_chk_step
         $error("STEP_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   // Bit NUM_SRC of each stage carries pll_locked_i, lower bits the sources.
   logic [NA-1:0]      sync_q [SYNC_STAGES];
   logic [NA-1:0]      sync_last;
   logic               req;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [KW-1:0]      k_q, k_d;
   logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
   logic [NUM_SRC+1:0] cause_q, cause_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= {pll_locked_i, src_rst_ni};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign req       = ~(&sync_last) | sw_rst_i;

   // Set has priority over clear so a request present during the clear is kept.
   always_comb begin
      cause_d = cause_clr_i ? '0 : cause_q;
      cause_d = cause_d | {sw_rst_i, ~sync_last};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         k_q     <= '0;
         rst_n_q <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         rst_n_q <= rst_n_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      rst_n_d = rst_n_q;
      case (state_q)
         ST_ASSERT: begin
            rst_n_d = '0;
            k_d     = '0;
            if (req) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               cnt_d = '0;
               if (NUM_OUT == 1) begin
                  state_d = ST_RUN;
                  rst_n_d = '1;
               end else begin
                  state_d = ST_RELEASE;
                  rst_n_d = NUM_OUT'(1);
                  k_d     = KW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RELEASE: begin
            if (req) begin
               state_d = ST_ASSERT;
               rst_n_d = '0;
               cnt_d   = '0;
               k_d     = '0;
            end else if (cnt_q == STEP_LAST) begin
               cnt_d          = '0;
               rst_n_d[k_q]   = 1'b1;
               if (k_q == K_LAST) begin
                  state_d = ST_RUN;
                  k_d     = '0;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RUN: begin
            rst_n_d = '1;
            cnt_d   = '0;
            k_d     = '0;
            if (req) begin
               state_d = ST_ASSERT;
               rst_n_d = '0;
            end
         end
         default: begin
            state_d = ST_ASSERT;
            rst_n_d = '0;
            cnt_d   = '0;
            k_d     = '0;
         end
      endcase
   end

   assign rst_no  = rst_n_q;
   assign busy_o  = ~(&rst_n_q);
   assign cause_o = cause_q;

endmodule

// File: tb/tb_cdc_reset_sequencer.sv
// Bench for cdc_reset_sequencer: default instance plus a NUM_OUT=1 / short-timing
// instance; expectations are queued per absolute clock edge and checked after it.
module tb_cdc_reset_sequencer;

   logic       clk_i;
   logic       rst_i;
   logic [1:0] src_rst_ni;
   logic       pll_locked_i;
   logic       sw_rst_i;
   logic       cause_clr_i;
   logic [2:0] rst_no;
   logic       busy_o;
   logic [3:0] cause_o;
   logic [0:0] rst1_no;
   logic       busy1_o;
   logic [3:0] cause1_o;

   int edge_cnt = 0;
   int n_total  = 0;
   int n_bad    = 0;

   cdc_reset_sequencer dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .src_rst_ni   (src_rst_ni),
      .pll_locked_i (pll_locked_i),
      .sw_rst_i     (sw_rst_i),
      .cause_clr_i  (cause_clr_i),
      .rst_no       (rst_no),
      .busy_o       (busy_o),
      .cause_o      (cause_o)
   );

   cdc_reset_sequencer #(
      .NUM_SRC     (2),
      .SYNC_STAGES (3),
      .NUM_OUT     (1),
      .HOLD_CYCLES (1),
      .STEP_CYCLES (1)
   ) dut1 (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .src_rst_ni   (2'b11),
      .pll_locked_i (1'b1),
      .sw_rst_i     (1'b0),
      .cause_clr_i  (1'b0),
      .rst_no       (rst1_no),
      .busy_o       (busy1_o),
      .cause_o      (cause1_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   // scoreboard
   typedef struct {
      int         which;
      int         edge_n;
      logic [2:0] rst_n;
      logic       busy;
      logic [3:0] cause;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   task automatic push(input int which, input int edge_n, input logic [2:0] rst_n,
                       input logic busy, input logic [3:0] cause, input string name);
      exp_t e;
      e.which  = which;
      e.edge_n = edge_n;
      e.rst_n  = rst_n;
      e.busy   = busy;
      e.cause  = cause;
      e.name   = name;
      exp_q.push_back(e);
   endtask

   always @(posedge clk_i) begin
      #1;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].edge_n == edge_cnt) begin
            logic [2:0] g_rst;
            logic       g_busy;
            logic [3:0] g_cause;
            g_rst   = (exp_q[i].which == 0) ? rst_no  : {2'b00, rst1_no};
            g_busy  = (exp_q[i].which == 0) ? busy_o  : busy1_o;
            g_cause = (exp_q[i].which == 0) ? cause_o : cause1_o;
            n_total++;
            if (g_rst !== exp_q[i].rst_n || g_busy !== exp_q[i].busy ||
                g_cause !== exp_q[i].cause) begin
               n_bad++;
               $display("FAIL %s: dut%0d edge %0d got rst_no=%b busy=%b cause=%b, want rst_no=%b busy=%b cause=%b",
                        exp_q[i].name, exp_q[i].which, edge_cnt, g_rst, g_busy, g_cause,
                        exp_q[i].rst_n, exp_q[i].busy, exp_q[i].cause);
            end
            exp_q.delete(i);
         end
      end
   end

   // vector table: inputs held for n cycles, outputs expected after the last edge
   typedef struct {
      string      name;
      logic [1:0] src_n;
      logic       pll;
      logic       sw;
      logic       clr;
      int         n;
      logic [2:0] rst_n;
      logic       busy;
      logic [3:0] cause;
   } vec_t;

   vec_t tbl [13];

   // driver
   task automatic drive(input logic [1:0] src_n, input logic pll, input logic sw,
                        input logic clr);
      src_rst_ni   = src_n;
      pll_locked_i = pll;
      sw_rst_i     = sw;
      cause_clr_i  = clr;
   endtask

   initial begin
      int r, f, g;
      tbl[0]  = '{"clr_after_boot",  2'b11, 1'b1, 1'b0, 1'b1,  1, 3'b111, 1'b0, 4'b0000};
      tbl[1]  = '{"src1_not_yet",    2'b01, 1'b1, 1'b0, 1'b0,  2, 3'b111, 1'b0, 4'b0000};
      tbl[2]  = '{"src1_asserts",    2'b01, 1'b1, 1'b0, 1'b0,  1, 3'b000, 1'b1, 4'b0010};
      tbl[3]  = '{"src1_hold_end",   2'b11, 1'b1, 1'b0, 1'b0, 17, 3'b000, 1'b1, 4'b0010};
      tbl[4]  = '{"src1_rel0",       2'b11, 1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b1, 4'b0010};
      tbl[5]  = '{"rel0_steady",     2'b11, 1'b1, 1'b0, 1'b0,  2, 3'b001, 1'b1, 4'b0010};
      tbl[6]  = '{"sw_in_release",   2'b11, 1'b1, 1'b1, 1'b0,  1, 3'b000, 1'b1, 4'b1010};
      tbl[7]  = '{"sw_hold_end",     2'b11, 1'b1, 1'b0, 1'b0, 15, 3'b000, 1'b1, 4'b1010};
      tbl[8]  = '{"sw_rel0",         2'b11, 1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b1, 4'b1010};
      tbl[9]  = '{"sw_step1_end",    2'b11, 1'b1, 1'b0, 1'b0,  7, 3'b001, 1'b1, 4'b1010};
      tbl[10] = '{"sw_rel1",         2'b11, 1'b1, 1'b0, 1'b0,  1, 3'b011, 1'b1, 4'b1010};
      tbl[11] = '{"sw_step2_end",    2'b11, 1'b1, 1'b0, 1'b0,  7, 3'b011, 1'b1, 4'b1010};
      tbl[12] = '{"sw_rel2_run",     2'b11, 1'b1, 1'b0, 1'b0,  1, 3'b111, 1'b0, 4'b1010};

      // power-up: rst_i high for edges 1..3, so the last high edge R = 3
      rst_i = 1'b1;
      drive(2'b11, 1'b1, 1'b0, 1'b0);
      r = 3;
      push(0, r,      3'b000, 1'b1, 4'b0000, "reset_state");
      push(0, r + 1,  3'b000, 1'b1, 4'b0111, "boot_cause");
      push(0, r + 17, 3'b000, 1'b1, 4'b0111, "boot_pre_rel0");
      push(0, r + 18, 3'b001, 1'b1, 4'b0111, "boot_rel0");
      push(0, r + 25, 3'b001, 1'b1, 4'b0111, "boot_pre_rel1");
      push(0, r + 26, 3'b011, 1'b1, 4'b0111, "boot_rel1");
      push(0, r + 33, 3'b011, 1'b1, 4'b0111, "boot_pre_rel2");
      push(0, r + 34, 3'b111, 1'b0, 4'b0111, "boot_rel2");
      push(1, r,      3'b000, 1'b1, 4'b0000, "sweep_reset");
      push(1, r + 3,  3'b000, 1'b1, 4'b0111, "sweep_pre_rel");
      push(1, r + 4,  3'b001, 1'b0, 4'b0111, "sweep_rel");
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (35) @(negedge clk_i);

      // table-driven phases starting in RUN
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].src_n, tbl[i].pll, tbl[i].sw, tbl[i].clr);
         push(0, edge_cnt + tbl[i].n, tbl[i].rst_n, tbl[i].busy, tbl[i].cause, tbl[i].name);
         repeat (tbl[i].n) @(negedge clk_i);
      end

      // sw reset together with a cause clear, then a PLL glitch at hold count 10
      f = edge_cnt + 1;
      push(0, f,      3'b000, 1'b1, 4'b1000, "sw_clr_same_cycle");
      push(0, f + 12, 3'b000, 1'b1, 4'b1000, "pll_not_yet");
      push(0, f + 13, 3'b000, 1'b1, 4'b1100, "pll_cause");
      push(0, f + 16, 3'b000, 1'b1, 4'b1100, "hold_restarted");
      push(0, f + 29, 3'b000, 1'b1, 4'b1100, "pll_pre_rel0");
      push(0, f + 30, 3'b001, 1'b1, 4'b1100, "pll_rel0");
      push(0, f + 46, 3'b111, 1'b0, 4'b1100, "pll_run");
      drive(2'b11, 1'b1, 1'b1, 1'b1);
      @(negedge clk_i);
      drive(2'b11, 1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk_i);
      drive(2'b11, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk_i);
      drive(2'b11, 1'b1, 1'b0, 1'b0);
      repeat (35) @(negedge clk_i);

      // cause clear while the src0 request is active
      g = edge_cnt + 1;
      push(0, g + 1,  3'b111, 1'b0, 4'b1100, "src0_not_yet");
      push(0, g + 2,  3'b000, 1'b1, 4'b1101, "src0_asserts");
      push(0, g + 3,  3'b000, 1'b1, 4'b0001, "clr_set_wins");
      push(0, g + 21, 3'b000, 1'b1, 4'b0001, "src0_pre_rel0");
      push(0, g + 22, 3'b001, 1'b1, 4'b0001, "src0_rel0");
      push(0, g + 38, 3'b111, 1'b0, 4'b0001, "src0_run");
      drive(2'b10, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk_i);
      drive(2'b10, 1'b1, 1'b0, 1'b1);
      @(negedge clk_i);
      drive(2'b10, 1'b1, 1'b0, 1'b0);
      @(negedge clk_i);
      drive(2'b11, 1'b1, 1'b0, 1'b0);
      repeat (36) @(negedge clk_i);

      // report
      foreach (exp_q[i]) begin
         n_total++;
         n_bad++;
         $display("FAIL %s: expectation for edge %0d never checked, want rst_no=%b",
                  exp_q[i].name, exp_q[i].edge_n, exp_q[i].rst_n);
      end
      if (n_total < 37) begin
         n_bad++;
         $display("FAIL only %0d checks performed, want at least 37", n_total);
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      if (n_bad == 0) begin
         $display("PASS");
      end else begin
         $display("FAIL");
      end
      $finish;
   end

endmodule
